ieee_fp_adder: RTL and testbench
================================

Name: ieee_fp_adder

Overview:
Single-precision IEEE-754 (binary32) floating-point adder/subtractor. Computes number1 + number2 or number1 − number2 with round-to-nearest-even. The combinational datapath feeds one output register, so the block drops into a clocked arithmetic pipeline as a single-cycle-latency ALU stage.

Parameters:
None (format fixed at binary32: 1 sign, 8 exponent bits with bias 127, 23 fraction bits).

Ports:
clk      input   1   system clock, rising edge active
rst_n    input   1   asynchronous reset, active low
number1  input   32  operand A, binary32
number2  input   32  operand B, binary32
op       input   1   0 = A + B, 1 = A − B
result   output  32  registered binary32 result

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: asserting rst_n low clears result to 32'h00000000 immediately; result stays 0 until the first rising clk edge after release.
- Latency:
  - Inputs sampled on the rising clk edge.
  - result reflects those inputs after that edge and holds until the next edge.
  - Fully pipelined: one new operation per cycle. No handshake, no valid signal.
- Subtraction: B's sign is inverted when op=1, then the add path is used.
- Datapath:
  1. Unpack operands, prepend the hidden 1.
  2. Swap so the larger magnitude is the first operand.
  3. Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits. Shifts ≥ 26 collapse into sticky.
  4. Add or subtract significands according to the effective sign.
  5. Normalize:
     - carry-out: shift right by 1, exponent +1;
     - otherwise: leading-zero count, shift left, exponent − count.
  6. Round to nearest, ties to even. A rounding carry renormalizes the result (exponent +1).
- Sign:
  - Taken from the larger-magnitude operand.
  - An exact-zero difference of finite operands gives +0.
  - (+0)+(+0) = +0; (−0)+(−0) = −0; mixed-sign zero sum = +0.
- Special cases (checked before arithmetic; they take priority):
  - Either operand NaN (exp=FF, frac≠0): result is canonical 32'h7FC00000.
  - Inf − Inf, including +Inf + −Inf after op: result is 32'h7FC00000.
  - Inf op finite: result is that Inf with the effective sign.
  - Zero operand: result is the other operand, with its sign adjusted for op.
- Overflow: a post-round exponent ≥ 255 gives ±Inf (exp=FF, frac=0).
- Underflow and subnormals: see Optional Feature.
- No exception flags are produced.

Optional Feature:
SUBNORMAL_EN
- Defined:
  - Subnormal inputs (exp=0, frac≠0) are used with hidden bit 0 and effective exponent 1.
  - Results below the normal range are denormalized with correct rounding (gradual underflow).
  - A result that rounds up into the normal range gets exp=1.
- Undefined (default):
  - Subnormal inputs are treated as signed zero.
  - Any result with biased exponent ≤ 0 after normalization flushes to zero with the computed sign.

Test Plan:
1. Reset: rst_n low mid-operation → result = 32'h00000000 immediately, before any clk edge.
2. Cancellation: number1=32'h40ADF06F, number2=32'h40ADEAB3, op=1 → result = 32'h3A378000 one edge later.
3. Mixed-sign add: 32'hC0000000 + 32'h41100000, op=0 → 32'h40E00000 (7.0). Identity: 32'h3F800000 + 32'h3F800000 → 32'h40000000.
4. Rounding tie: 32'h3F800000 + 32'h33800000, op=0 → 32'h3F800000 (tie rounds to even). Exact cancellation: 32'h3F800000 − 32'h3F800000, op=1 → 32'h00000000.
5. Overflow: 32'h7F7FFFFF + 32'h7F7FFFFF → 32'h7F800000. Invalid: 32'h7F800000 − 32'h7F800000, op=1 → 32'h7FC00000. NaN input: 32'h7FC00001 + 32'h3F800000 → 32'h7FC00000.
6. Back-to-back: apply tests 2–4 on consecutive cycles → each result appears exactly one edge after its inputs, with no bubbles.

Source files
------------

// File: rtl/ieee_fp_adder.sv
// rtl/ieee_fp_adder.sv - binary32 adder/subtractor, round-to-nearest-even, one registered stage (optional SUBNORMAL_EN)
module ieee_fp_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] number1,
    input  logic [31:0] number2,
    input  logic        op,
    output logic [31:0] result
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Unpacked operands; B's sign already reflects the requested operation
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic        hid_a, hid_b;
    logic [7:0]  eeff_a, eeff_b;

    assign sa = number1[31];
    assign sb = number2[31] ^ op;
    assign ea = number1[30:23];
    assign eb = number2[30:23];
    assign fa = number1[22:0];
    assign fb = number2[22:0];

    assign nan_a = (ea == 8'hFF) && (fa != 23'd0);
    assign nan_b = (eb == 8'hFF) && (fb != 23'd0);
    assign inf_a = (ea == 8'hFF) && (fa == 23'd0);
    assign inf_b = (eb == 8'hFF) && (fb == 23'd0);

`ifdef SUBNORMAL_EN
    // Subnormals carry a hidden 0 and sit at effective exponent 1
    assign zero_a = (ea == 8'd0) && (fa == 23'd0);
    assign zero_b = (eb == 8'd0) && (fb == 23'd0);
    assign hid_a  = (ea != 8'd0);
    assign hid_b  = (eb != 8'd0);
    assign eeff_a = (ea == 8'd0) ? 8'd1 : ea;
    assign eeff_b = (eb == 8'd0) ? 8'd1 : eb;
`else
    // Subnormal inputs are indistinguishable from signed zero
    assign zero_a = (ea == 8'd0);
    assign zero_b = (eb == 8'd0);
    assign hid_a  = 1'b1;
    assign hid_b  = 1'b1;
    assign eeff_a = ea;
    assign eeff_b = eb;
`endif

    // Larger magnitude goes to the "l" side so the subtraction never goes negative
    logic        a_ge;
    logic        sl, ss;
    logic [7:0]  el, es, diff;
    logic [23:0] sig_l, sig_s;

    assign a_ge  = number1[30:0] >= number2[30:0];
    assign sl    = a_ge ? sa : sb;
    assign ss    = a_ge ? sb : sa;
    assign el    = a_ge ? eeff_a : eeff_b;
    assign es    = a_ge ? eeff_b : eeff_a;
    assign sig_l = a_ge ? {hid_a, fa} : {hid_b, fb};
    assign sig_s = a_ge ? {hid_b, fb} : {hid_a, fa};
    assign diff  = el - es;

    // Align the smaller significand, keeping guard/round and a sticky OR of everything shifted out
    logic [49:0] wide;
    logic [26:0] aligned;
    always_comb begin
        wide = {sig_s, 26'd0} >> diff;
        if (diff >= 8'd26)
            aligned = {26'd0, |sig_s};
        else
            aligned = {wide[49:24], |wide[23:0]};
    end

    // Magnitude add or subtract depending on the effective signs
    logic        eff_sub;
    logic [27:0] sum;
    assign eff_sub = sl ^ ss;
    assign sum = eff_sub ? ({1'b0, sig_l, 3'b000} - {1'b0, aligned})
                         : ({1'b0, sig_l, 3'b000} + {1'b0, aligned});

    // Leading-zero count of the non-carry part; 27 means the sum is zero
    logic [4:0] lz;
    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
    end

    // Normalize: a carry shifts right, otherwise shift out the leading zeros
    logic [4:0]        shamt;
    logic [26:0]       norm;
    logic signed [9:0] exp_n;
    always_comb begin
`ifdef SUBNORMAL_EN
        // Never normalize below exponent 1; what is left over becomes a subnormal
        if ({3'b000, lz} < el)
            shamt = lz;
        else
            shamt = 5'(el - 8'd1);
`else
        shamt = lz;
`endif
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, el} + 10'd1;
        end else begin
            norm  = sum[26:0] << shamt;
            exp_n = {2'b00, el} - {5'd0, shamt};
        end
    end

    // Round to nearest even; a carry out of the significand bumps the exponent
    logic              round_up;
    logic [24:0]       rounded;
    logic [23:0]       mant_f;
    logic signed [9:0] exp_f;
    always_comb begin
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (rounded[24]) begin
            mant_f = rounded[24:1];
            exp_f  = exp_n + 10'sd1;
        end else begin
            mant_f = rounded[23:0];
            exp_f  = exp_n;
        end
    end

    // Pack the arithmetic result, covering zero, underflow and overflow
    logic [31:0] arith;
    always_comb begin
        if (sum == 28'd0)
            arith = 32'h0000_0000;
`ifndef SUBNORMAL_EN
        else if (exp_n <= 10'sd0)
            arith = {sl, 31'd0};
`endif
        else if (exp_f >= 10'sd255)
            arith = {sl, 8'hFF, 23'd0};
        else if (!mant_f[23])
            arith = {sl, 8'd0, mant_f[22:0]};
        else
            arith = {sl, exp_f[7:0], mant_f[22:0]};
    end

    // Special operands take priority over the arithmetic path
    logic [31:0] next_result;
    always_comb begin
        if (nan_a || nan_b)
            next_result = QNAN;
        else if (inf_a && inf_b && (sa != sb))
            next_result = QNAN;
        else if (inf_a)
            next_result = {sa, 8'hFF, 23'd0};
        else if (inf_b)
            next_result = {sb, 8'hFF, 23'd0};
        else if (zero_a && zero_b)
            next_result = {sa & sb, 31'd0};
        else if (zero_a)
            next_result = {sb, number2[30:0]};
        else if (zero_b)
            next_result = number1;
        else
            next_result = arith;
    end

    // Single output register: result follows the inputs one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            result <= 32'h0000_0000;
        else
            result <= next_result;
    end

endmodule

// File: tb/tb_ieee_fp_adder.sv
// tb/tb_ieee_fp_adder.sv - directed-vector bench for ieee_fp_adder
module tb_ieee_fp_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] number1;
    logic [31:0] number2;
    logic        op;
    logic [31:0] result;

    int total;
    int passed;

    ieee_fp_adder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .number1 (number1),
        .number2 (number2),
        .op      (op),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] expv);
        total++;
        assert (result === expv) passed++;
        else $error("FAIL %s: result=%h expected=%h", tag, result, expv);
    endtask

    task automatic vec(input logic [31:0] a, input logic [31:0] b, input logic o,
                       input logic [31:0] expv, input string tag);
        number1 = a;
        number2 = b;
        op      = o;
        @(posedge clk);
        #1;
        check(tag, expv);
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        rst_n   = 1'b0;
        number1 = 32'h0;
        number2 = 32'h0;
        op      = 1'b0;
        #2;
        check("reset_init", 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back directed vectors, one result per edge
        vec(32'h40AD_F06F, 32'h40AD_EAB3, 1'b1, 32'h3A37_8000, "cancellation");
        vec(32'hC000_0000, 32'h4110_0000, 1'b0, 32'h40E0_0000, "mixed_sign_add");
        vec(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, "one_plus_one");
        vec(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, "tie_to_even");
        vec(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, "exact_cancel");
        vec(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, "overflow");
        vec(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, "inf_minus_inf");
        vec(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, "nan_input");
        vec(32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, "round_up");
        vec(32'h40A0_0000, 32'h4040_0000, 1'b1, 32'h4000_0000, "five_minus_three");
        vec(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, "neg_zero_sum");
        vec(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, "mixed_zero_sum");
        vec(32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, "zero_minus_one");
        vec(32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, "inf_plus_finite");
        vec(32'h3F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000, "finite_minus_neginf");

        // repeat the pipelined sequence of cancellation/add/rounding cases
        vec(32'h40AD_F06F, 32'h40AD_EAB3, 1'b1, 32'h3A37_8000, "b2b_cancellation");
        vec(32'hC000_0000, 32'h4110_0000, 1'b0, 32'h40E0_0000, "b2b_mixed");
        vec(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, "b2b_identity");
        vec(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, "b2b_tie");
        vec(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, "b2b_exact_cancel");

        // asynchronous reset in the middle of operation
        number1 = 32'h4110_0000;
        number2 = 32'h3F80_0000;
        op      = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_value", 32'h4120_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reset_held", 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        vec(32'hC000_0000, 32'h4110_0000, 1'b0, 32'h40E0_0000, "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
